// File: rtl/tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_pkg
// Brief    : Shared types and constants for the transmit mixer path. Also
//            holds the NCO sign-magnitude to two's-complement helper.
// Revision : 1.0
// ============================================================================
package tx_pkg;

    // Keying envelope states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } tx_state_t;

    localparam logic [10:0]        GAIN_FULL = 11'd1024;
    localparam logic signed [11:0] DAC_MAX   = 12'sh7FF;
    localparam logic signed [11:0] DAC_MIN   = 12'sh800;

    // 19-bit sign-magnitude (bit 18 = sign) to signed 18-bit. The magnitude is
    // negated when the sign is set, then the LSB is dropped.
    function automatic logic signed [17:0] sm_to_tc(input logic [18:0] sm);
        logic signed [18:0] tc;
        tc = sm[18] ? -$signed({1'b0, sm[17:0]}) : $signed({1'b0, sm[17:0]});
        return 18'(tc >>> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nco1.sv
`default_nettype none
// ============================================================================
// Module   : nco1
// Brief    : Phase-to-amplitude NCO with sign-magnitude cos/sin outputs.
//            CALCTYPE 0 gives a full-scale quadrature square wave, any other
//            value a quadrature triangle approximation. LAT clocks of latency.
// Revision : 1.0
// ============================================================================
module nco1 #(
    parameter int CALCTYPE = 3,
    parameter int LAT      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] phi,
    output logic [18:0] cos_sm,
    output logic [18:0] sin_sm
);

    logic [1:0]  w_quad;
    logic [17:0] w_frac;
    logic [17:0] w_cos_mag;
    logic [17:0] w_sin_mag;
    logic [18:0] w_cos;
    logic [18:0] w_sin;
    logic [37:0] r_pipe [LAT];

    // Quadrant decode and magnitude shaping; cos is negative in quadrants 1-2
    always_comb begin
        w_quad = phi[31:30];
        w_frac = 18'(phi[29:0] >> 12);
        if (CALCTYPE == 0) begin
            w_cos_mag = '1;
            w_sin_mag = '1;
        end else begin
            w_cos_mag = w_quad[0] ? w_frac : ~w_frac;
            w_sin_mag = w_quad[0] ? ~w_frac : w_frac;
        end
        w_cos = {w_quad[1] ^ w_quad[0], w_cos_mag};
        w_sin = {w_quad[1], w_sin_mag};
    end

    // Latency pipeline, first stage registers the fresh amplitude pair
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) r_pipe[k] <= '0;
        end else begin
            r_pipe[0] <= {w_cos, w_sin};
            for (int k = 1; k < LAT; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    assign cos_sm = r_pipe[LAT-1][37:19];
    assign sin_sm = r_pipe[LAT-1][18:0];

endmodule
`default_nettype wire

// File: rtl/tx_mix1.sv
`default_nettype none
// ============================================================================
// Module   : tx_mix1
// Brief    : Transmit upconversion mixer. Holds the last accepted baseband
//            I/Q, mixes with the NCO (I*cos - Q*sin), rounds/saturates to a
//            12-bit DAC word and applies a key-click suppressing gain ramp.
// Revision : 1.0
// ============================================================================
module tx_mix1
    import tx_pkg::*;
#(
    parameter int CALCTYPE = 3,
    parameter int NCO_LAT  = 2,
    parameter int RAMP_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        phi,
    input  logic               tx_en,
    input  logic signed [17:0] i_data,
    input  logic signed [17:0] q_data,
    input  logic               iq_valid,
    output logic               iq_ready,
    output logic signed [11:0] dac,
    output logic               tx_active
);

    localparam int                  c_presc_w    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(RAMP_DIV - 1);

    tx_state_t              r_state, w_state_nxt;
    logic [10:0]            r_gain, w_gain_nxt;
    logic [c_presc_w-1:0]   r_presc, w_presc_nxt;
    logic                   w_tick;
    logic                   r_iq_ready;
    logic signed [17:0]     r_held_i, r_held_q;

    logic [18:0]            w_cos_sm, w_sin_sm;
    logic signed [17:0]     r_cos, r_sin;
    logic signed [35:0]     r_pi, r_pq;
    logic signed [36:0]     w_diff, w_rnd_full;
    logic signed [12:0]     w_rnd;
    logic signed [11:0]     w_sat, r_m;
    logic signed [23:0]     w_gprod, w_gr;
    logic signed [11:0]     w_dac, r_dac;

    nco1 #(
        .CALCTYPE (CALCTYPE),
        .LAT      (NCO_LAT)
    ) u_nco (
        .clk    (clk),
        .rst    (rst),
        .phi    (phi),
        .cos_sm (w_cos_sm),
        .sin_sm (w_sin_sm)
    );

    assign w_tick = (r_presc == c_presc_last);

    // Envelope next-state, gain step and prescaler; endpoints beat tx_en changes
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        unique case (r_state)
            IDLE: begin
                w_gain_nxt = '0;
                if (tx_en) w_state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
                if (r_gain == GAIN_FULL) begin
                    w_state_nxt = ON;
                end else if (w_tick && (r_gain == GAIN_FULL - 11'd1)) begin
                    w_gain_nxt  = GAIN_FULL;
                    w_state_nxt = ON;
                end else if (!tx_en) begin
                    w_state_nxt = RAMP_DOWN;
                end else if (w_tick) begin
                    w_gain_nxt = r_gain + 11'd1;
                end
            end
            ON: begin
                w_gain_nxt = GAIN_FULL;
                if (!tx_en) w_state_nxt = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (r_gain == 11'd0) begin
                    w_state_nxt = IDLE;
                end else if (tx_en) begin
                    w_state_nxt = RAMP_UP;
                end else if (w_tick) begin
                    w_gain_nxt = r_gain - 11'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gain_nxt  = '0;
            end
        endcase

        if ((w_state_nxt != r_state) || (r_state == IDLE) || (r_state == ON) || w_tick)
            w_presc_nxt = '0;
        else
            w_presc_nxt = r_presc + 1'b1;
    end

    // Envelope registers; iq_ready tracks the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gain     <= '0;
            r_presc    <= '0;
            r_iq_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gain     <= w_gain_nxt;
            r_presc    <= w_presc_nxt;
            r_iq_ready <= (w_state_nxt == RAMP_UP) || (w_state_nxt == ON);
        end
    end

    // Zero-order hold of the baseband sample, cleared when keying ends
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held_i <= '0;
            r_held_q <= '0;
        end else if ((w_state_nxt == IDLE) && (r_state != IDLE)) begin
            r_held_i <= '0;
            r_held_q <= '0;
        end else if (iq_valid && r_iq_ready) begin
            r_held_i <= i_data;
            r_held_q <= q_data;
        end
    end

    // Difference, half-up rounding to 12 bits with saturation, then gain scaling
    always_comb begin
        w_diff     = $signed({r_pi[35], r_pi}) - $signed({r_pq[35], r_pq});
        w_rnd_full = w_diff + 37'sd8388608;
        w_rnd      = 13'(w_rnd_full >>> 24);
        if (w_rnd[12] != w_rnd[11])
            w_sat = w_rnd[12] ? DAC_MIN : DAC_MAX;
        else
            w_sat = w_rnd[11:0];
        w_gprod = r_m * $signed({1'b0, r_gain});
        w_gr    = w_gprod + 24'sd512;
        w_dac   = 12'(w_gr >>> 10);
    end

    // Datapath pipeline: convert, multiply, round/saturate, gain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cos <= '0;
            r_sin <= '0;
            r_pi  <= '0;
            r_pq  <= '0;
            r_m   <= '0;
            r_dac <= '0;
        end else begin
            r_cos <= sm_to_tc(w_cos_sm);
            r_sin <= sm_to_tc(w_sin_sm);
            r_pi  <= r_held_i * r_cos;
            r_pq  <= r_held_q * r_sin;
            r_m   <= w_sat;
            r_dac <= w_dac;
        end
    end

    assign iq_ready  = r_iq_ready;
    assign dac       = r_dac;
    assign tx_active = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tx_mix1.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_mix1
// Brief    : Directed self-checking bench for tx_mix1 (square-wave NCO build,
//            RAMP_DIV = 1, NCO_LAT = 2).
// Revision : 1.0
// ============================================================================
module tb_tx_mix1;
    import tx_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        phi;
    logic               tx_en;
    logic signed [17:0] i_data;
    logic signed [17:0] q_data;
    logic               iq_valid;
    logic               iq_ready;
    logic signed [11:0] dac;
    logic               tx_active;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] ph_hist [0:8191];

    tx_mix1 #(
        .CALCTYPE (0),
        .NCO_LAT  (2),
        .RAMP_DIV (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .phi       (phi),
        .tx_en     (tx_en),
        .i_data    (i_data),
        .q_data    (q_data),
        .iq_valid  (iq_valid),
        .iq_ready  (iq_ready),
        .dac       (dac),
        .tx_active (tx_active)
    );

    always #5 clk = ~clk;

    // Advance one clock; values are sampled 1 time unit after the edge
    task automatic tick();
        ph_hist[cyc] = phi;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Square-wave NCO reference at full gain: cos<0 in quadrants 1,2; sin<0 in 2,3
    function automatic int model_dac(input logic [31:0] ph, input int iv, input int qv);
        longint cs, ss, s, v;
        cs = (ph[31] ^ ph[30]) ? -64'sd131072 : 64'sd131071;
        ss = ph[31] ? -64'sd131072 : 64'sd131071;
        s  = iv * cs - qv * ss;
        v  = (s + 64'sd8388608) >>> 24;
        if (v > 2047)  v = 2047;
        if (v < -2048) v = -2048;
        return int'(v);
    endfunction

    initial begin
        int n, t, d, u;

        // Reset with a valid word offered
        rst = 1'b1; tx_en = 1'b0; iq_valid = 1'b1;
        i_data = 18'sd5; q_data = 18'sd5; phi = 32'd0;
        repeat (3) begin
            tick();
            chk("rst_ready",  iq_ready,  0);
            chk("rst_dac",    dac,       0);
            chk("rst_active", tx_active, 0);
        end
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("idle_ready", iq_ready,     0);
            chk("idle_dac",   dac,          0);
            chk("idle_held",  dut.r_held_i, 0);
        end

        // Ramp up from IDLE to ON with I full scale, phi = 0
        i_data = 18'sd131071; q_data = 18'sd0; tx_en = 1'b1;
        n = cyc;
        tick();                                      // n+1
        chk("up_active", tx_active, 1);
        chk("up_state",  dut.r_state, RAMP_UP);
        chk("up_ready",  iq_ready, 1);
        repeat (1022) tick();
        tick();                                      // n+1024
        chk("up_state_1024", dut.r_state, RAMP_UP);
        chk("up_gain_1024",  dut.r_gain, 1023);
        tick();                                      // n+1025
        chk("on_state", dut.r_state, ON);
        chk("on_gain",  dut.r_gain, 1024);
        chk("on_dac_prev_gain", dac, 1023);
        tick();
        chk("on_dac_full", dac, 1024);
        if (cyc != n + 1026) chk("ramp_cycle_count", cyc, n + 1026);

        // Phase sweep through all quadrants with I = Q = full scale
        i_data = 18'sd131071; q_data = 18'sd131071;
        for (int k = 0; k < 80; k++) begin
            phi = {2'(k), 30'($urandom)};
            tick();
            if (k >= 8) chk("sweep_dac", dac, model_dac(ph_hist[cyc-6], 131071, 131071));
        end

        // Zero-order hold and 4-cycle transfer latency
        phi = 32'd0; iq_valid = 1'b0;
        repeat (8) tick();
        chk("hold_pre_dac", dac, 0);
        i_data = 18'sd65536; q_data = 18'sd0; iq_valid = 1'b1;
        t = cyc;
        tick();                                      // t+1
        iq_valid = 1'b0; i_data = -18'sd1000; q_data = 18'sd777;
        repeat (2) tick();                           // t+3
        chk("xfer1_t3", dac, 0);
        tick();                                      // t+4
        chk("xfer1_t4", dac, 512);
        repeat (5) tick();
        chk("hold_dac",  dac, 512);
        chk("hold_reg",  dut.r_held_i, 65536);
        i_data = -18'sd65536; q_data = 18'sd0; iq_valid = 1'b1;
        tick();
        iq_valid = 1'b0; i_data = 18'sd3;
        repeat (2) tick();
        chk("xfer2_t3", dac, 512);
        tick();
        chk("xfer2_t4", dac, -512);
        i_data = 18'sd65536; q_data = 18'sd0; iq_valid = 1'b1;
        tick();
        iq_valid = 1'b0;
        repeat (6) tick();
        chk("restore_dac", dac, 512);

        // Full ramp down with m = 512: dac = round(512*gain/1024)
        tx_en = 1'b0;
        d = cyc;
        tick();                                      // d+1
        chk("dn_state", dut.r_state, RAMP_DOWN);
        chk("dn_ready", iq_ready, 0);
        chk("dn_gain",  dut.r_gain, 1024);
        repeat (599) tick();                         // d+600
        chk("dn_dac_426", dac, 213);
        tick();
        chk("dn_dac_425", dac, 213);
        tick();
        chk("dn_dac_424", dac, 212);
        repeat (423) tick();                         // d+1025
        chk("dn_gain_zero",   dut.r_gain, 0);
        chk("dn_active_zero", tx_active, 1);
        tick();                                      // d+1026
        chk("idle_state",  dut.r_state, IDLE);
        chk("idle_active", tx_active, 0);
        chk("idle_held_i", dut.r_held_i, 0);
        chk("idle_dac",    dac, 0);

        // Ramp up, drop at gain 512, re-raise 100 cycles later
        i_data = 18'sd65536; q_data = 18'sd0; iq_valid = 1'b1; tx_en = 1'b1;
        u = cyc;
        tick();                                      // u+1
        chk("re_state", dut.r_state, RAMP_UP);
        repeat (512) tick();                         // u+513
        chk("re_gain_512", dut.r_gain, 512);
        tx_en = 1'b0;
        tick();                                      // u+514
        chk("re_dn_state", dut.r_state, RAMP_DOWN);
        chk("re_dn_gain",  dut.r_gain, 512);
        tick();
        chk("re_dn_gain2", dut.r_gain, 511);
        repeat (98) tick();                          // u+613
        chk("re_gain_413", dut.r_gain, 413);
        tx_en = 1'b1;
        tick();                                      // u+614
        chk("re_up_state", dut.r_state, RAMP_UP);
        chk("re_up_gain",  dut.r_gain, 413);
        tick();
        chk("re_up_gain2", dut.r_gain, 414);
        chk("re_dac_413",  dac, 207);
        tick();
        chk("re_dac_414",  dac, 207);
        tick();
        chk("re_dac_415",  dac, 208);

        // One-cycle reset in the middle of the ramp
        rst = 1'b1;
        tick();
        chk("mid_rst_state",  dut.r_state, IDLE);
        chk("mid_rst_dac",    dac, 0);
        chk("mid_rst_ready",  iq_ready, 0);
        chk("mid_rst_held_i", dut.r_held_i, 0);
        chk("mid_rst_held_q", dut.r_held_q, 0);
        chk("mid_rst_active", tx_active, 0);
        rst = 1'b0; tx_en = 1'b0;
        tick();
        chk("post_rst_dac", dac, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
